// File: rtl/pid_seq_pkg.sv
// Shared state encoding and default widths for the PID lock sequencer.
package pid_seq_pkg;

    localparam int unsigned DefaultErrW = 14;
    localparam int unsigned DefaultCntW = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StLocked  = 2'd2,
        StFault   = 2'd3
    } state_e;

endpackage

// File: rtl/ramp_trig_gen.sv
// Ramp falling-edge detector and the one-cycle-delayed PID update strobe.
module ramp_trig_gen (
    input  logic clk,
    input  logic rst_i,
    input  logic ramp_i,
    output logic edge_o,
    output logic trigger_o
);

    logic ramp_q;
    logic trig_q;

    // ramp_q clears on reset so a low ramp right after reset is not an edge
    always_ff @(posedge clk) begin
        if (rst_i) begin
            ramp_q <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            ramp_q <= ramp_i;
            trig_q <= edge_o;
        end
    end

    assign edge_o    = ramp_q & ~ramp_i;
    assign trigger_o = trig_q;

endmodule

// File: rtl/pid_lock_sequencer.sv
// Lock acquisition sequencer: shadows setpoint/gains into the PID datapath once per ramp
// period and tracks acquire/lock/loss from the captured loop error.
module pid_lock_sequencer
    import pid_seq_pkg::*;
#(
    parameter int unsigned ERR_W = DefaultErrW,
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             ramp_i,
    input  logic [ERR_W-1:0] err_i,
    input  logic             err_valid_i,
    input  logic             enable_i,
    input  logic             relock_en_i,
    input  logic [ERR_W-1:0] cfg_sp_i,
    input  logic [ERR_W-1:0] cfg_kp_i,
    input  logic [ERR_W-1:0] cfg_ki_i,
    input  logic [ERR_W-1:0] cfg_kd_i,
    input  logic [ERR_W-1:0] cfg_thr_i,
    input  logic [CNT_W-1:0] cfg_settle_i,
    input  logic [CNT_W-1:0] cfg_loss_i,
    output logic [ERR_W-1:0] set_sp_o,
    output logic [ERR_W-1:0] set_kp_o,
    output logic [ERR_W-1:0] set_ki_o,
    output logic [ERR_W-1:0] set_kd_o,
    output logic             trigger_enable_o,
    output logic             int_rst_o,
    output logic [1:0]       state_o,
    output logic             locked_o,
    output logic [CNT_W-1:0] loss_cnt_o
);

    logic ramp_edge;

    ramp_trig_gen u_trig (
        .clk       (clk),
        .rst_i     (rst_i),
        .ramp_i    (ramp_i),
        .edge_o    (ramp_edge),
        .trigger_o (trigger_enable_o)
    );

    state_e           state_q, state_d;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W:0]   err_ext, err_abs;
    logic             in_thr;
    logic [CNT_W-1:0] settle_q, settle_d, loss_run_q, loss_run_d, loss_cnt_q, loss_cnt_d;
    logic [CNT_W-1:0] settle_tgt, loss_tgt;
    logic [ERR_W-1:0] sp_q, sp_d, kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
    logic             int_rst_q, int_rst_d;

    // One extra bit so the most negative error has a representable magnitude
    always_comb begin
        err_ext = {err_q[ERR_W-1], err_q};
        err_abs = err_ext[ERR_W] ? -err_ext : err_ext;
        in_thr  = (err_abs <= {1'b0, cfg_thr_i});
    end

    assign settle_tgt = (cfg_settle_i == '0) ? CNT_W'(1) : cfg_settle_i;
    assign loss_tgt   = (cfg_loss_i == '0) ? CNT_W'(1) : cfg_loss_i;

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        loss_run_d = loss_run_q;
        loss_cnt_d = loss_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (ramp_edge && enable_i) state_d = StAcquire;
            end
            StAcquire: begin
                if (!enable_i) begin
                    state_d = StIdle;
                end else if (ramp_edge) begin
                    if (in_thr) begin
                        settle_d = settle_q + CNT_W'(1);
                        if (settle_d >= settle_tgt) state_d = StLocked;
                    end else begin
                        settle_d = '0;
                    end
                end
            end
            StLocked: begin
                if (!enable_i) begin
                    state_d = StIdle;
                end else if (ramp_edge) begin
                    if (!in_thr) begin
                        loss_run_d = loss_run_q + CNT_W'(1);
                        if (loss_run_d >= loss_tgt) begin
                            if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + CNT_W'(1);
                            state_d = relock_en_i ? StAcquire : StFault;
                        end
                    end else begin
                        loss_run_d = '0;
                    end
                end
            end
            StFault: begin
                if (!enable_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) begin
            settle_d   = '0;
            loss_run_d = '0;
        end
    end

    // Gains follow cfg only at edges while active; the entry strobe into ACQUIRE keeps int_rst
    always_comb begin
        sp_d      = ramp_edge ? cfg_sp_i : sp_q;
        kp_d      = kp_q;
        ki_d      = ki_q;
        kd_d      = kd_q;
        int_rst_d = int_rst_q;
        if (!(state_d == StAcquire || state_d == StLocked)) begin
            kp_d      = '0;
            ki_d      = '0;
            kd_d      = '0;
            int_rst_d = 1'b1;
        end else if (ramp_edge) begin
            kp_d      = cfg_kp_i;
            ki_d      = cfg_ki_i;
            kd_d      = cfg_kd_i;
            int_rst_d = (state_d == StAcquire) && (state_q != StAcquire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= StIdle;
            err_q      <= '0;
            settle_q   <= '0;
            loss_run_q <= '0;
            loss_cnt_q <= '0;
            sp_q       <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            kd_q       <= '0;
            int_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            if (err_valid_i) err_q <= err_i;
            settle_q   <= settle_d;
            loss_run_q <= loss_run_d;
            loss_cnt_q <= loss_cnt_d;
            sp_q       <= sp_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            kd_q       <= kd_d;
            int_rst_q  <= int_rst_d;
        end
    end

    assign set_sp_o   = sp_q;
    assign set_kp_o   = kp_q;
    assign set_ki_o   = ki_q;
    assign set_kd_o   = kd_q;
    assign int_rst_o  = int_rst_q;
    assign state_o    = state_q;
    assign locked_o   = (state_q == StLocked);
    assign loss_cnt_o = loss_cnt_q;

endmodule

// File: doc/pid_lock_sequencer.md
PID_LOCK_SEQUENCER -- requirements
Module: pid_lock_sequencer

Interface
REQ-001 SHALL have parameter ERR_W, default 14, meaning width of the error, setpoint, gain and threshold words.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the settle, loss and statistics counters.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 ramp_i  in  1  ramp sync level; its falling edge is the loop trigger.
REQ-006 err_i  in  ERR_W  signed loop error (setpoint minus input).
REQ-007 err_valid_i  in  1  err_i qualifier.
REQ-008 enable_i  in  1  arm lock sequence.
REQ-009 relock_en_i  in  1  allow automatic reacquire after lock loss.
REQ-010 cfg_sp_i, cfg_kp_i, cfg_ki_i, cfg_kd_i  in  ERR_W each  software setpoint and gains.
REQ-011 cfg_thr_i  in  ERR_W  unsigned lock threshold on |error|.
REQ-012 cfg_settle_i, cfg_loss_i  in  CNT_W each  required consecutive in-threshold triggers to lock, and out-of-threshold triggers to declare loss.
REQ-013 set_sp_o, set_kp_o, set_ki_o, set_kd_o  out  ERR_W each  shadowed values to the PID datapath.
REQ-014 trigger_enable_o  out  1  one-cycle PID update strobe.
REQ-015 int_rst_o  out  1  integrator reset to the PID datapath.
REQ-016 state_o  out  2  current state; locked_o  out  1; loss_cnt_o  out  CNT_W  saturating lock-loss count.

Function
REQ-017 An edge SHALL be detected in cycle N when the registered ramp_i was 1 and ramp_i is 0; a first-cycle low after reset SHALL NOT count as an edge.
REQ-018 State, shadow outputs and int_rst_o SHALL update at the end of cycle N; trigger_enable_o SHALL pulse high for exactly cycle N+1, so PID inputs are stable one cycle before the strobe.
REQ-019 Triggers SHALL be issued in every state.
REQ-020 Error SHALL be captured on err_valid_i; decisions SHALL use |err_q| computed ERR_W+1 bits wide (|-2^(ERR_W-1)| = 2^(ERR_W-1)); in-threshold means |err_q| <= cfg_thr_i.
REQ-021 States: IDLE=0, ACQUIRE=1, LOCKED=2, FAULT=3.
REQ-022 IDLE: set_kp/ki/kd_o = 0, int_rst_o = 1; at an edge with enable_i=1, go to ACQUIRE.
REQ-023 ACQUIRE: the entry edge SHALL keep int_rst_o = 1 for that strobe; int_rst_o = 0 from the next edge onward.
REQ-024 ACQUIRE: each edge increments settle_cnt if in-threshold, else clears it; when settle_cnt reaches max(cfg_settle_i,1), go to LOCKED on that edge.
REQ-025 LOCKED: locked_o = 1; each out-of-threshold edge increments loss_run, each in-threshold edge clears it; when loss_run reaches max(cfg_loss_i,1), increment loss_cnt_o (saturating at all-ones) and go to ACQUIRE if relock_en_i, else FAULT.
REQ-026 FAULT: gains 0, int_rst_o = 1; go to IDLE when enable_i = 0.
REQ-027 enable_i = 0 in ACQUIRE or LOCKED SHALL force IDLE on the next cycle without waiting for an edge; if this coincides with an edge, IDLE wins.
REQ-028 In ACQUIRE and LOCKED, shadow outputs SHALL reload from cfg_* at every edge only; mid-period cfg changes SHALL NOT reach the outputs.
REQ-029 set_sp_o SHALL reload at every edge in all states.
REQ-030 Counters SHALL clear on every state change.

Reset
REQ-031 rst_i SHALL force state IDLE, all shadow outputs 0, int_rst_o = 1, trigger_enable_o = 0, locked_o = 0, loss_cnt_o = 0, err_q = 0, ramp register = 0, counters 0.
REQ-032 rst_i asserted mid-operation SHALL take effect on the next edge and suppress any pending strobe.

Structure
REQ-033 Package pid_seq_pkg SHALL hold the state encoding and the ERR_W and CNT_W defaults.
REQ-034 Edge detection and strobe delay SHALL be sub-module ramp_trig_gen.

Verification
REQ-035 Enable=1, thr=100, settle=4, err=50, ramp period 1000 -> ACQUIRE at 1st edge with int_rst_o=1 at strobe, int_rst_o=0 at 2nd edge, LOCKED at 5th edge.
REQ-036 ACQUIRE, err=200 at 3rd edge -> settle_cnt clears; LOCKED reached 4 in-threshold edges later.
REQ-037 LOCKED, loss=3, err=-8192, relock_en=0 -> FAULT on 3rd edge, loss_cnt_o=1, gains 0; enable_i=0 -> IDLE.
REQ-038 Same with relock_en=1 -> ACQUIRE with int_rst_o=1 at that strobe.
REQ-039 cfg_kp changes 10 cycles before an edge -> set_kp_o changes in edge cycle N, strobe in N+1; enable_i drop coincident with an edge -> IDLE.
REQ-040 rst_i pulse during LOCKED -> all outputs at reset values in the next cycle, with no strobe.
